// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, funct codes,
// ALU operation encodings, PC source selects, FSM states and opcode classes.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_OP_NONE = 3'd0;
  localparam logic [2:0] ALU_OP_ADD  = 3'd1;
  localparam logic [2:0] ALU_OP_SUB  = 3'd2;
  localparam logic [2:0] ALU_OP_AND  = 3'd3;
  localparam logic [2:0] ALU_OP_OR   = 3'd4;
  localparam logic [2:0] ALU_OP_SLT  = 3'd5;
  localparam logic [2:0] ALU_OP_GTZ  = 3'd7;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_ADDI,
    CL_LW,
    CL_SW,
    CL_BGTZ,
    CL_J,
    CL_NONE
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_RTYPE: return CL_RTYPE;
      OP_ADDI:  return CL_ADDI;
      OP_LW:    return CL_LW;
      OP_SW:    return CL_SW;
      OP_BGTZ:  return CL_BGTZ;
      OP_J:     return CL_J;
      default:  return CL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational opcode/funct decoder: ALU operation, R-type operand select and
// a legality flag for unknown opcodes or unsupported R-type funct codes.
module multicycle_control_alu_decode
  import multicycle_control_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [5:0]          i_op,
  input  logic [5:0]          i_funct,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_i_or_r,
  output logic                o_legal
);

  logic [2:0] w_alu;

  always_comb begin
    w_alu    = ALU_OP_NONE;
    o_i_or_r = 1'b0;
    o_legal  = 1'b1;
    case (op_class(i_op))
      CL_RTYPE: begin
        o_i_or_r = 1'b1;
        case (i_funct)
          FN_ADD:  w_alu = ALU_OP_ADD;
          FN_SUB:  w_alu = ALU_OP_SUB;
          FN_AND:  w_alu = ALU_OP_AND;
          FN_OR:   w_alu = ALU_OP_OR;
          FN_SLT:  w_alu = ALU_OP_SLT;
          default: o_legal = 1'b0;
        endcase
      end
      CL_ADDI, CL_LW, CL_SW: w_alu = ALU_OP_ADD;
      CL_BGTZ:               w_alu = ALU_OP_GTZ;
      CL_J:                  w_alu = ALU_OP_NONE;
      default:               o_legal = 1'b0;
    endcase
  end

  assign o_alu_op = ALU_OP_W'(w_alu);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// bus-ready wait counter, sticky illegal-instruction and bus-timeout flags.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                gtz,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                i_or_r,
  output logic                reg_write,
  output logic                load,
  output logic                illegal,
  output logic                bus_err,
  output logic [2:0]          state
);

  state_e              r_state;
  logic [5:0]          r_op_q;
  logic [5:0]          r_funct_q;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_illegal;
  logic                r_bus_err;

  logic [5:0]          w_dec_op;
  logic [5:0]          w_dec_funct;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_i_or_r;
  logic                w_legal;
  logic                w_wait_last;
  op_class_e           w_class;

  // In DECODE the decoder sees the live IR so legality is known before the
  // latch; everywhere its outputs are used (EXEC/WB) it sees the latched copy.
  assign w_dec_op    = (r_state == ST_DECODE) ? op    : r_op_q;
  assign w_dec_funct = (r_state == ST_DECODE) ? funct : r_funct_q;

  multicycle_control_alu_decode #(
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_decode (
    .i_op     (w_dec_op),
    .i_funct  (w_dec_funct),
    .o_alu_op (w_alu_op),
    .o_i_or_r (w_i_or_r),
    .o_legal  (w_legal)
  );

  assign w_class = op_class(r_op_q);

  // This wait cycle would bring the counter to TIMEOUT.
  assign w_wait_last = (TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_op_q     <= '0;
      r_funct_q  <= '0;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_wait_cnt <= '0;
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            r_state <= ST_DECODE;
          end else if (w_wait_last) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          r_op_q    <= op;
          r_funct_q <= funct;
          if (w_legal) begin
            r_state <= ST_EXEC;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= ST_HALT;
          end
        end
        ST_EXEC: begin
          case (w_class)
            CL_RTYPE, CL_ADDI: r_state <= ST_WB;
            CL_LW, CL_SW:      r_state <= ST_MEM;
            default:           r_state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            r_state <= (w_class == CL_SW) ? ST_FETCH : ST_WB;
          end else if (w_wait_last) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        ST_WB:   r_state <= ST_FETCH;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_SEQ;
    alu_op    = '0;
    i_or_r    = 1'b0;
    reg_write = 1'b0;
    load      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_EXEC: begin
        alu_op = w_alu_op;
        i_or_r = w_i_or_r;
        if (w_class == CL_BGTZ) begin
          pc_write = gtz;
          pc_src   = PC_SRC_BRANCH;
        end else if (w_class == CL_J) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_class == CL_SW);
      end
      ST_WB: begin
        reg_write = 1'b1;
        load      = (w_class == CL_LW);
        i_or_r    = w_i_or_r;
      end
      default: ;
    endcase
  end

  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign state   = r_state;

endmodule
